// File: rtl/strobe_scheduler.sv
// strobe_scheduler: per-channel prescaled strobe generation with a
// round-robin grant, done handshake and grant timeout.
module strobe_scheduler #(
   parameter int NUM_CH     = 4,
   parameter int PRESCALE_W = 8,
   parameter int TIMEOUT    = 15
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      strobe_i,
   input  logic [NUM_CH-1:0]         ch_enable_i,
   input  logic                      cfg_valid_i,
   input  logic [$clog2(NUM_CH)-1:0] cfg_ch_i,
   input  logic [PRESCALE_W-1:0]     cfg_prescale_i,
   output logic                      cfg_ready_o,
   input  logic [NUM_CH-1:0]         ch_done_i,
   output logic [NUM_CH-1:0]         ch_strobe_o,
   output logic [NUM_CH-1:0]         overrun_o,
   output logic                      timeout_o,
   output logic                      busy_o
);
   localparam int IW = $clog2(NUM_CH);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t                state;
   state_t                state_nx;
   logic [PRESCALE_W-1:0] cnt   [NUM_CH];
   logic [PRESCALE_W-1:0] presc [NUM_CH];
   logic [NUM_CH-1:0]     pend;
   logic [NUM_CH-1:0]     hit;
   logic [NUM_CH-1:0]     cfg_hit;
   logic [NUM_CH-1:0]     clr;
   logic [NUM_CH-1:0]     req;
   logic [IW-1:0]         sel;
   logic [IW-1:0]         last_grant;
   logic [IW-1:0]         pick;
   logic [IW-1:0]         idx;
   logic                  found;
   logic                  fire;
   logic                  expire;
   logic [TW-1:0]         wcnt;

   assign cfg_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);
   assign req         = pend & ch_enable_i;

   always_comb begin
      hit     = '0;
      cfg_hit = '0;
      clr     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         hit[i]     = strobe_i && ch_enable_i[i] && (cnt[i] == presc[i]);
         cfg_hit[i] = cfg_valid_i && cfg_ready_o && (int'(cfg_ch_i) == i);
         clr[i]     = fire && (int'(sel) == i);
      end
   end

   // first requester strictly after the last grant, wrapping
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = IW'((int'(last_grant) + k) % NUM_CH);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_nx = state;
      fire     = 1'b0;
      expire   = 1'b0;
      unique case (state)
         IDLE: begin
            if (found) state_nx = ISSUE;
         end
         ISSUE: begin
            fire     = req[sel];
            state_nx = req[sel] ? WAIT : IDLE;
         end
         WAIT: begin
            if (ch_done_i[sel]) begin
               state_nx = IDLE;
            end else if (wcnt == TW'(TIMEOUT)) begin
               state_nx = IDLE;
               expire   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         sel         <= '0;
         last_grant  <= IW'(NUM_CH - 1);
         wcnt        <= '0;
         ch_strobe_o <= '0;
         timeout_o   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && found) sel <= pick;
         if (fire) last_grant <= sel;
         ch_strobe_o <= fire ? (NUM_CH'(1) << sel) : '0;
         timeout_o   <= expire;
         wcnt        <= (state == WAIT) ? wcnt + TW'(1) : '0;
      end
   end

   // a new tick beats the grant clear and is not an overrun
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend      <= '0;
         overrun_o <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]   <= '0;
            presc[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_hit[i]) begin
               presc[i]     <= cfg_prescale_i;
               cnt[i]       <= '0;
               pend[i]      <= 1'b0;
               overrun_o[i] <= 1'b0;
            end else if (!ch_enable_i[i]) begin
               cnt[i]  <= '0;
               pend[i] <= 1'b0;
            end else if (hit[i]) begin
               cnt[i]  <= '0;
               pend[i] <= 1'b1;
               if (pend[i] && !clr[i]) overrun_o[i] <= 1'b1;
            end else begin
               if (strobe_i) cnt[i] <= cnt[i] + PRESCALE_W'(1);
               if (clr[i]) pend[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_strobe_scheduler.sv
// tb_strobe_scheduler: directed checks of prescaling, round-robin
// grants, timeout, busy config writes and reset abandonment.
module tb_strobe_scheduler;
   logic       clk_i;
   logic       rst_i;
   logic       strobe_i;
   logic [3:0] ch_enable_i;
   logic       cfg_valid_i;
   logic [1:0] cfg_ch_i;
   logic [7:0] cfg_prescale_i;
   logic       cfg_ready_o;
   logic [3:0] ch_done_i;
   logic [3:0] ch_strobe_o;
   logic [3:0] overrun_o;
   logic       timeout_o;
   logic       busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   logic       done_en;
   int         done_dly;
   logic [3:0] force_done;
   logic [3:0] h [4];

   logic [3:0] seq [$];
   int         st  [$];
   int         sts [$];
   int         to_t[$];

   strobe_scheduler #(
      .NUM_CH(4),
      .PRESCALE_W(8),
      .TIMEOUT(15)
   ) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .strobe_i(strobe_i),
      .ch_enable_i(ch_enable_i),
      .cfg_valid_i(cfg_valid_i),
      .cfg_ch_i(cfg_ch_i),
      .cfg_prescale_i(cfg_prescale_i),
      .cfg_ready_o(cfg_ready_o),
      .ch_done_i(ch_done_i),
      .ch_strobe_o(ch_strobe_o),
      .overrun_o(overrun_o),
      .timeout_o(timeout_o),
      .busy_o(busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // done responder: echoes the strobe done_dly cycles later
   initial begin
      ch_done_i = '0;
      for (int j = 0; j < 4; j++) h[j] = '0;
      forever begin
         @(posedge clk_i);
         #2;
         h[3] = h[2];
         h[2] = h[1];
         h[1] = h[0];
         h[0] = ch_strobe_o;
         ch_done_i = (done_en ? h[done_dly] : 4'b0) | force_done;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk_i);
      #1;
      cyc++;
   endtask

   task automatic clear_log();
      seq.delete();
      st.delete();
      sts.delete();
      to_t.delete();
   endtask

   task automatic run(input int n, input int per);
      for (int k = 0; k < n; k++) begin
         strobe_i = (per > 0) && (k % per == 0);
         if (strobe_i) sts.push_back(cyc);
         cycle();
         strobe_i = 1'b0;
         if (ch_strobe_o != 0) begin
            seq.push_back(ch_strobe_o);
            st.push_back(cyc);
         end
         if (timeout_o) to_t.push_back(cyc);
      end
   endtask

   task automatic do_reset();
      rst_i          = 1'b1;
      strobe_i       = 1'b0;
      ch_enable_i    = '0;
      cfg_valid_i    = 1'b0;
      cfg_ch_i       = '0;
      cfg_prescale_i = '0;
      force_done     = '0;
      done_en        = 1'b0;
      done_dly       = 0;
      cycle();
      cycle();
      rst_i = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] ch, input logic [7:0] p);
      cfg_valid_i    = 1'b1;
      cfg_ch_i       = ch;
      cfg_prescale_i = p;
      cycle();
      cfg_valid_i = 1'b0;
   endtask

   initial begin
      rst_i          = 1'b1;
      strobe_i       = 1'b0;
      ch_enable_i    = '0;
      cfg_valid_i    = 1'b0;
      cfg_ch_i       = '0;
      cfg_prescale_i = '0;
      force_done     = '0;
      done_en        = 1'b0;
      done_dly       = 0;

      // reset state
      do_reset();
      check("rst_strobe", 32'(ch_strobe_o), 32'h0);
      check("rst_overrun", 32'(overrun_o), 32'h0);
      check("rst_timeout", 32'(timeout_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);
      check("rst_ready", 32'(cfg_ready_o), 32'h1);

      // all channels prescale 0, one tick: round robin from ch0
      ch_enable_i = 4'b1111;
      done_en     = 1'b1;
      done_dly    = 0;
      clear_log();
      run(1, 1);
      run(20, 0);
      check("rr_count", 32'(seq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("rr_val%0d", i),
               (seq.size() > i) ? 32'(seq[i]) : 32'hdead,
               32'(4'b0001 << i));
         check($sformatf("rr_time%0d", i),
               (st.size() > i) ? 32'(st[i]) : 32'hdead,
               32'(sts[0] + 3 + 3 * i));
      end
      check("rr_overrun", 32'(overrun_o), 32'h0);

      // ch0 prescale 3, tick every 10, done after 2 cycles
      do_reset();
      cfg_write(2'd0, 8'd3);
      ch_enable_i = 4'b0001;
      done_en     = 1'b1;
      done_dly    = 2;
      clear_log();
      run(80, 10);
      check("ps3_count", 32'(seq.size()), 32'd2);
      check("ps3_val0", (seq.size() > 0) ? 32'(seq[0]) : 32'hdead, 32'h1);
      check("ps3_val1", (seq.size() > 1) ? 32'(seq[1]) : 32'hdead, 32'h1);
      check("ps3_time0", (st.size() > 0) ? 32'(st[0]) : 32'hdead,
            32'(sts[3] + 3));
      check("ps3_time1", (st.size() > 1) ? 32'(st[1]) : 32'hdead,
            32'(sts[7] + 3));
      check("ps3_overrun", 32'(overrun_o), 32'h0);
      check("ps3_timeouts", 32'(to_t.size()), 32'd0);

      // ch1 never done, others' done ignored: timeout and overrun
      do_reset();
      ch_enable_i = 4'b0010;
      force_done  = 4'b1101;
      clear_log();
      run(40, 5);
      check("to_val0", (seq.size() > 0) ? 32'(seq[0]) : 32'hdead, 32'h2);
      check("to_time0", (st.size() > 0) ? 32'(st[0]) : 32'hdead,
            32'(sts[0] + 3));
      check("to_count", 32'(to_t.size()), 32'd2);
      check("to_pulse0", (to_t.size() > 0) ? 32'(to_t[0]) : 32'hdead,
            32'(sts[0] + 19));
      check("to_regrant", (st.size() > 1) ? 32'(st[1]) : 32'hdead,
            32'(sts[0] + 21));
      check("to_pulse1", (to_t.size() > 1) ? 32'(to_t[1]) : 32'hdead,
            32'(sts[0] + 37));
      check("to_overrun", 32'(overrun_o), 32'h2);

      // config write while busy: held off, then restarts counter
      do_reset();
      force_done = '0;
      cfg_write(2'd2, 8'd9);
      ch_enable_i = 4'b0100;
      run(15, 5);
      ch_enable_i = 4'b0110;
      run(1, 1);
      run(2, 0);
      check("cfg_busy", 32'(busy_o), 32'h1);
      check("cfg_notready", 32'(cfg_ready_o), 32'h0);
      cfg_valid_i    = 1'b1;
      cfg_ch_i       = 2'd2;
      cfg_prescale_i = 8'd5;
      force_done     = 4'b0010;
      cycle();
      check("cfg_ready", 32'(cfg_ready_o), 32'h1);
      force_done = '0;
      cycle();
      cfg_valid_i = 1'b0;
      ch_enable_i = 4'b0100;
      done_en     = 1'b1;
      done_dly    = 0;
      clear_log();
      run(30, 5);
      check("cfg_count", 32'(seq.size()), 32'd1);
      check("cfg_val", (seq.size() > 0) ? 32'(seq[0]) : 32'hdead, 32'h4);
      check("cfg_time", (st.size() > 0) ? 32'(st[0]) : 32'hdead,
            32'(sts[5] + 3));

      // reset during WAIT with ch3 granted
      do_reset();
      ch_enable_i = 4'b1000;
      clear_log();
      run(1, 1);
      run(2, 0);
      check("wr_busy", 32'(busy_o), 32'h1);
      check("wr_strobe", 32'(ch_strobe_o), 32'h8);
      rst_i = 1'b1;
      cycle();
      check("wr_rst_busy", 32'(busy_o), 32'h0);
      check("wr_rst_strobe", 32'(ch_strobe_o), 32'h0);
      check("wr_rst_timeout", 32'(timeout_o), 32'h0);
      check("wr_rst_overrun", 32'(overrun_o), 32'h0);
      check("wr_rst_ready", 32'(cfg_ready_o), 32'h1);
      rst_i      = 1'b0;
      force_done = 4'b1000;
      cycle();
      force_done = '0;
      clear_log();
      run(20, 0);
      check("wr_no_strobe", 32'(seq.size()), 32'd0);
      check("wr_no_timeout", 32'(to_t.size()), 32'd0);
      check("wr_idle", 32'(busy_o), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/strobe_scheduler.md
STROBE_SCHEDULER -- requirements
Module: strobe_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4: number of wave channels served (2..8).
REQ-002 Parameter PRESCALE_W, default 8: width of each per-channel prescale value.
REQ-003 Parameter TIMEOUT, default 15: max cycles waited for a channel done before abandoning the grant.
REQ-004 clk_i  in  1: single system clock, all logic on rising edge.
REQ-005 rst_i  in  1: synchronous, active-high reset.
REQ-006 strobe_i  in  1: base sample tick, one-cycle pulse.
REQ-007 ch_enable_i  in  NUM_CH: per-channel enable, level.
REQ-008 cfg_valid_i  in  1: config write request.
REQ-009 cfg_ch_i  in  clog2(NUM_CH): target channel of config write.
REQ-010 cfg_prescale_i  in  PRESCALE_W: new prescale value.
REQ-011 cfg_ready_o  out  1: config write accepted when cfg_valid_i & cfg_ready_o.
REQ-012 ch_done_i  in  NUM_CH: per-channel completion pulse for the issued update.
REQ-013 ch_strobe_o  out  NUM_CH: one-hot update strobe, registered, one cycle wide.
REQ-014 overrun_o  out  NUM_CH: sticky per-channel overrun flags.
REQ-015 timeout_o  out  1: one-cycle pulse when a grant is abandoned.
REQ-016 busy_o  out  1: high whenever FSM is not IDLE.

Function
REQ-017 Per channel: counter (PRESCALE_W bits), prescale register, pending flag; counter advances only on strobe_i with channel enabled.
REQ-018 On strobe_i with enabled channel and counter == prescale: counter -> 0, pending set; else counter +1; prescale 0 = pending on every strobe_i.
REQ-019 Pending set while already pending SHALL set overrun_o[i]; pending stays 1, no queuing beyond one.
REQ-020 Disabled channel: counter held 0, pending cleared, never granted; overrun_o preserved.
REQ-021 FSM states IDLE, ISSUE, WAIT.
REQ-022 IDLE: if any pending, select first pending channel searching upward from last_grant+1 (modulo NUM_CH), -> ISSUE.
REQ-023 ISSUE (1 cycle): ch_strobe_o[sel] high on the registered output in the cycle after ISSUE is entered, pending[sel] cleared, last_grant <= sel, -> WAIT.
REQ-024 WAIT: ch_done_i[sel] -> IDLE; ch_done_i of non-selected channels ignored.
REQ-025 WAIT exceeding TIMEOUT cycles without done: timeout_o pulses one cycle, -> IDLE.
REQ-026 Latency pending-to-strobe from IDLE: 2 cycles; at most one grant in flight.
REQ-027 Pending set and cleared for same channel in same cycle: set wins, no overrun.
REQ-028 cfg_ready_o = 1 only in IDLE; accepted write loads prescale[cfg_ch_i], zeroes that counter, clears that pending and overrun flag.
REQ-029 cfg_ch_i >= NUM_CH: write accepted, no state changed.
REQ-030 Counter compare uses equality only; prescale lowered below current count wraps counter through max value to 0 naturally, no special case.

Reset
REQ-031 rst_i high on a clock edge: FSM -> IDLE, all counters, prescales, pending, overrun 0, last_grant = NUM_CH-1.
REQ-032 Outputs during/after reset: ch_strobe_o 0, overrun_o 0, timeout_o 0, busy_o 0, cfg_ready_o 1.
REQ-033 Reset mid-WAIT abandons the grant without timeout_o pulse; done pulses after reset are ignored.

Verification
REQ-034 Ch0 enabled, prescale 3, strobe_i every 10 cycles, done 2 cycles after strobe -> ch_strobe_o=4'b0001 once per 4 ticks, no overrun.
REQ-035 All 4 channels prescale 0, one strobe_i -> ch_strobe_o sequence 0001,0010,0100,1000 after reset (round-robin from ch0).
REQ-036 Ch1 prescale 0, done never returned, strobe_i every 5 cycles -> timeout_o pulse 16 cycles after strobe, overrun_o[1]=1.
REQ-037 Config write ch2 prescale 5 while busy -> cfg_ready_o 0 until IDLE, then accepted; counter restarts from 0.
REQ-038 rst_i asserted in WAIT with ch3 granted -> next cycle busy_o 0, all outputs 0, cfg_ready_o 1.
